jtbubl_rom_arb: RTL and testbench

- Shares one SDRAM read port among the three program-ROM requesters:
  - main CPU, 18-bit byte address.
  - sub CPU, 15-bit byte address.
  - MCU, 12-bit byte address.
- Each requester gets a one-word cache and an ok/data pair, which feeds the existing rom_cs/rom_ok wait-state logic.
- Sits between the main/sub/MCU block and the SDRAM controller.
- Uses round-robin scheduling so no CPU starves while another spins in a ROM loop.

---
 rtl/jtbubl_rom_arb_pkg.sv | 57 +++++
 rtl/jtbubl_rom_arb_if.sv | 42 ++++
 rtl/jtbubl_rom_slot.sv | 47 ++++
 rtl/jtbubl_rom_arb.sv | 154 +++++++++++++++
 tb/tb_jtbubl_rom_arb.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/jtbubl_rom_arb_pkg.sv
// Shared definitions for the program-ROM arbiter.
//   - requester ids, which also serve as the round-robin pointer values
//   - arbiter FSM state encoding
//   - default SDRAM word offsets of the three ROM regions
//   - round-robin helpers: next requester and pick of a pending requester
package jtbubl_rom_arb_pkg;

  typedef enum logic [1:0] {
    REQ_MAIN = 2'd0,
    REQ_SUB  = 2'd1,
    REQ_MCU  = 2'd2
  } req_id_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Widest word tag among the requesters (main: 18-bit byte address).
  localparam int TAG_W = 17;

  localparam logic [21:0] DEF_MAIN_OFFSET = 22'h00_0000;
  localparam logic [21:0] DEF_SUB_OFFSET  = 22'h02_0000;
  localparam logic [21:0] DEF_MCU_OFFSET  = 22'h02_4000;

  typedef struct packed {
    logic    found;
    req_id_e id;
  } pick_t;

  function automatic req_id_e next_id(input req_id_e id);
    case (id)
      REQ_MAIN: next_id = REQ_SUB;
      REQ_SUB:  next_id = REQ_MCU;
      default:  next_id = REQ_MAIN;
    endcase
  endfunction

  // First pending requester, searching main->sub->mcu->main from ptr.
  function automatic pick_t rr_pick(input req_id_e ptr, input logic [2:0] pend);
    pick_t   res;
    req_id_e id;
    res.found = 1'b0;
    res.id    = REQ_MAIN;
    id        = ptr;
    for (int i = 0; i < 3; i++) begin
      if (!res.found && pend[id]) begin
        res.found = 1'b1;
        res.id    = id;
      end
      id = next_id(id);
    end
    return res;
  endfunction

endpackage

// File: rtl/jtbubl_rom_arb_if.sv
// Bus bundle between the CPU block, the ROM arbiter and the SDRAM controller.
//   slave  : the arbiter's view (takes CPU requests and SDRAM responses,
//            drives ok/data back to the CPUs and the SDRAM read request)
//   master : the surrounding system's view (CPUs plus SDRAM controller)
interface jtbubl_rom_arb_if #(
  parameter int SDRAM_AW = 22
);
  logic [17:0]         main_addr;
  logic                main_cs;
  logic                main_ok;
  logic [7:0]          main_data;

  logic [14:0]         sub_addr;
  logic                sub_cs;
  logic                sub_ok;
  logic [7:0]          sub_data;

  logic [11:0]         mcu_addr;
  logic                mcu_cs;
  logic                mcu_ok;
  logic [7:0]          mcu_data;

  logic [SDRAM_AW-1:0] sdram_addr;
  logic                sdram_req;
  logic                sdram_ack;
  logic                sdram_rdy;
  logic [15:0]         sdram_dout;

  modport slave (
    input  main_addr, main_cs, sub_addr, sub_cs, mcu_addr, mcu_cs,
           sdram_ack, sdram_rdy, sdram_dout,
    output main_ok, main_data, sub_ok, sub_data, mcu_ok, mcu_data,
           sdram_addr, sdram_req
  );

  modport master (
    output main_addr, main_cs, sub_addr, sub_cs, mcu_addr, mcu_cs,
           sdram_ack, sdram_rdy, sdram_dout,
    input  main_ok, main_data, sub_ok, sub_data, mcu_ok, mcu_data,
           sdram_addr, sdram_req
  );
endinterface

// File: rtl/jtbubl_rom_slot.sv
// One-word read cache for a single ROM requester.
//   clk24, rst : clock and asynchronous active-high reset
//   addr, cs   : requester byte address and chip select
//   fill       : one-cycle strobe writing fill_tag/fill_word and setting valid
//   ok         : cs with a tag hit on the cached word (combinational)
//   data       : byte lane of the cached word selected by addr[0]
//   miss       : cs without a hit; the requester needs an SDRAM read
module jtbubl_rom_slot #(
  parameter int AW = 18
) (
  input  logic          clk24,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          cs,
  input  logic          fill,
  input  logic [AW-2:0] fill_tag,
  input  logic [15:0]   fill_word,
  output logic          ok,
  output logic [7:0]    data,
  output logic          miss
);

  logic [AW-2:0] tag;
  logic [15:0]   word;
  logic          valid;
  logic          hit;

  // NOTE: only one word per requester, so every cache register gets a reset
  // value; a deep memory would clear just the valid bit instead.
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      tag   <= '0;
      word  <= '0;
      valid <= 1'b0;
    end else if (fill) begin
      tag   <= fill_tag;
      word  <= fill_word;
      valid <= 1'b1;
    end
  end

  assign hit  = cs && valid && (tag == addr[AW-1:1]);
  assign ok   = hit;
  assign data = addr[0] ? word[15:8] : word[7:0];
  assign miss = cs && !hit;

endmodule

// File: rtl/jtbubl_rom_arb.sv
// Shares one SDRAM read port among the main CPU, sub CPU and MCU program
// ROMs. Each requester has a one-word cache; misses are served one at a
// time in round-robin order so a CPU spinning in a ROM loop cannot starve
// the others.
//   clk24, rst : clock and asynchronous active-high reset
//   bus        : requester addr/cs/ok/data triplets and the SDRAM read port
//                (sdram_addr/req out, sdram_ack/rdy/dout in)
module jtbubl_rom_arb
  import jtbubl_rom_arb_pkg::*;
#(
  parameter int                  SDRAM_AW    = 22,
  parameter logic [SDRAM_AW-1:0] MAIN_OFFSET = SDRAM_AW'(DEF_MAIN_OFFSET),
  parameter logic [SDRAM_AW-1:0] SUB_OFFSET  = SDRAM_AW'(DEF_SUB_OFFSET),
  parameter logic [SDRAM_AW-1:0] MCU_OFFSET  = SDRAM_AW'(DEF_MCU_OFFSET)
) (
  input  logic            clk24,
  input  logic            rst,
  jtbubl_rom_arb_if.slave bus
);

  state_e              state, state_nxt;
  req_id_e             ptr, ptr_nxt;
  req_id_e             gnt, gnt_nxt;
  logic [TAG_W-1:0]    lat_tag, tag_nxt;
  logic                req_nxt;
  logic [SDRAM_AW-1:0] addr_nxt;
  logic [2:0]          pend;
  logic [2:0]          fill;
  pick_t               pick;
  logic [TAG_W-1:0]    pick_tag;
  logic [SDRAM_AW-1:0] pick_off;

  jtbubl_rom_slot #(.AW(18)) u_main (
    .clk24     (clk24),
    .rst       (rst),
    .addr      (bus.main_addr),
    .cs        (bus.main_cs),
    .fill      (fill[REQ_MAIN]),
    .fill_tag  (lat_tag[16:0]),
    .fill_word (bus.sdram_dout),
    .ok        (bus.main_ok),
    .data      (bus.main_data),
    .miss      (pend[REQ_MAIN])
  );

  jtbubl_rom_slot #(.AW(15)) u_sub (
    .clk24     (clk24),
    .rst       (rst),
    .addr      (bus.sub_addr),
    .cs        (bus.sub_cs),
    .fill      (fill[REQ_SUB]),
    .fill_tag  (lat_tag[13:0]),
    .fill_word (bus.sdram_dout),
    .ok        (bus.sub_ok),
    .data      (bus.sub_data),
    .miss      (pend[REQ_SUB])
  );

  jtbubl_rom_slot #(.AW(12)) u_mcu (
    .clk24     (clk24),
    .rst       (rst),
    .addr      (bus.mcu_addr),
    .cs        (bus.mcu_cs),
    .fill      (fill[REQ_MCU]),
    .fill_tag  (lat_tag[10:0]),
    .fill_word (bus.sdram_dout),
    .ok        (bus.mcu_ok),
    .data      (bus.mcu_data),
    .miss      (pend[REQ_MCU])
  );

  // NOTE: every signal written here gets a default first so no path through
  // the case leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    tag_nxt   = lat_tag;
    req_nxt   = bus.sdram_req;
    addr_nxt  = bus.sdram_addr;
    fill      = 3'b000;

    pick = rr_pick(ptr, pend);
    case (pick.id)
      REQ_SUB: begin
        pick_tag = TAG_W'(bus.sub_addr[14:1]);
        pick_off = SUB_OFFSET;
      end
      REQ_MCU: begin
        pick_tag = TAG_W'(bus.mcu_addr[11:1]);
        pick_off = MCU_OFFSET;
      end
      default: begin
        pick_tag = bus.main_addr[17:1];
        pick_off = MAIN_OFFSET;
      end
    endcase

    case (state)
      ST_IDLE: begin
        if (pick.found) begin
          gnt_nxt   = pick.id;
          tag_nxt   = pick_tag;
          // Offset addition wraps modulo 2^SDRAM_AW.
          addr_nxt  = pick_off + SDRAM_AW'(pick_tag);
          req_nxt   = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.sdram_ack) begin
          req_nxt = 1'b0;
          // Data arriving with the ack completes the read in the same step.
          if (bus.sdram_rdy) begin
            fill[gnt] = 1'b1;
            ptr_nxt   = next_id(gnt);
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (bus.sdram_rdy) begin
          fill[gnt] = 1'b1;
          ptr_nxt   = next_id(gnt);
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      ptr            <= REQ_MAIN;
      gnt            <= REQ_MAIN;
      lat_tag        <= '0;
      bus.sdram_req  <= 1'b0;
      bus.sdram_addr <= '0;
    end else begin
      state          <= state_nxt;
      ptr            <= ptr_nxt;
      gnt            <= gnt_nxt;
      lat_tag        <= tag_nxt;
      bus.sdram_req  <= req_nxt;
      bus.sdram_addr <= addr_nxt;
    end
  end

endmodule

// File: tb/tb_jtbubl_rom_arb.sv
// Directed bench for jtbubl_rom_arb: the bench plays the CPUs and the SDRAM
// controller by hand and compares against hand-computed values.
module tb_jtbubl_rom_arb;

  logic clk24 = 1'b0;
  logic rst;

  int check_cnt = 0;
  int pass_cnt  = 0;

  jtbubl_rom_arb_if #(.SDRAM_AW(22)) bus ();

  jtbubl_rom_arb dut (
    .clk24 (clk24),
    .rst   (rst),
    .bus   (bus)
  );

  always #20 clk24 = ~clk24;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk24);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!bus.sdram_req && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req"}, 32'(bus.sdram_req), 32'd1);
  endtask

  // Serve one read: check the address, ack after one held cycle, then rdy.
  task automatic serve(input string tag, input logic [21:0] exp_addr, input logic [15:0] dout);
    wait_req(tag);
    check({tag, "_addr"}, 32'(bus.sdram_addr), 32'(exp_addr));
    tick();
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    check({tag, "_drop"}, 32'(bus.sdram_req), 32'd0);
    bus.sdram_rdy  = 1'b1;
    bus.sdram_dout = dout;
    tick();
    bus.sdram_rdy  = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.main_addr  = '0;
    bus.main_cs    = 1'b0;
    bus.sub_addr   = '0;
    bus.sub_cs     = 1'b0;
    bus.mcu_addr   = '0;
    bus.mcu_cs     = 1'b0;
    bus.sdram_ack  = 1'b0;
    bus.sdram_rdy  = 1'b0;
    bus.sdram_dout = '0;

    // Reset state
    repeat (2) tick();
    check("rst_req",  32'(bus.sdram_req),  32'd0);
    check("rst_addr", 32'(bus.sdram_addr), 32'd0);
    check("rst_oks",  32'({bus.main_ok, bus.sub_ok, bus.mcu_ok}), 32'd0);
    check("rst_data", 32'({bus.main_data, bus.sub_data, bus.mcu_data}), 32'd0);
    rst = 1'b0;
    tick();

    // Single main miss: byte 0x11 -> word 0x8
    bus.main_addr = 18'h00011;
    bus.main_cs   = 1'b1;
    #1;
    check("t1_ok_pre", 32'(bus.main_ok), 32'd0);
    tick();
    check("t1_req",  32'(bus.sdram_req),  32'd1);
    check("t1_addr", 32'(bus.sdram_addr), 32'h000008);
    tick();
    check("t1_hold1", 32'(bus.sdram_req), 32'd1);
    tick();
    check("t1_hold2", 32'({bus.sdram_req, bus.sdram_addr}), 32'h400008);
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    check("t1_drop", 32'(bus.sdram_req), 32'd0);
    bus.sdram_rdy  = 1'b1;
    bus.sdram_dout = 16'hBEEF;
    #1;
    check("t1_ok_rdy", 32'(bus.main_ok), 32'd0);
    tick();
    bus.sdram_rdy = 1'b0;
    check("t1_ok",   32'(bus.main_ok),   32'd1);
    check("t1_data", 32'(bus.main_data), 32'hBE);
    bus.main_addr = 18'h00010;
    #1;
    check("t1_hit_ok",   32'(bus.main_ok),   32'd1);
    check("t1_hit_data", 32'(bus.main_data), 32'hEF);
    tick();
    check("t1_noreq", 32'(bus.sdram_req), 32'd0);

    // Simultaneous misses from a fresh pointer: main, sub, mcu
    bus.main_cs = 1'b0;
    reset_dut();
    bus.main_addr = 18'h00100;
    bus.sub_addr  = 15'h0002;
    bus.mcu_addr  = 12'h004;
    bus.main_cs   = 1'b1;
    bus.sub_cs    = 1'b1;
    bus.mcu_cs    = 1'b1;
    tick();
    serve("t2_main", 22'h000080, 16'h1122);
    check("t2_gap",       32'(bus.sdram_req), 32'd0);
    check("t2_main_ok",   32'({bus.main_ok, bus.sub_ok, bus.mcu_ok}), 32'b100);
    check("t2_main_data", 32'(bus.main_data), 32'h22);
    serve("t2_sub", 22'h020001, 16'h3344);
    serve("t2_mcu", 22'h024002, 16'h5566);
    check("t2_all_ok", 32'({bus.main_ok, bus.sub_ok, bus.mcu_ok}), 32'b111);
    check("t2_data",   32'({bus.main_data, bus.sub_data, bus.mcu_data}), 32'h224466);

    // Fairness: main misses again after each fill while sub waits
    bus.main_cs = 1'b0;
    bus.sub_cs  = 1'b0;
    bus.mcu_cs  = 1'b0;
    reset_dut();
    bus.main_addr = 18'h00200;
    bus.sub_addr  = 15'h0010;
    bus.main_cs   = 1'b1;
    bus.sub_cs    = 1'b1;
    tick();
    serve("t3_m1", 22'h000100, 16'h0102);
    bus.main_addr = 18'h00400;
    serve("t3_sub", 22'h020008, 16'h0304);
    serve("t3_m2", 22'h000200, 16'h0506);
    check("t3_ok",   32'({bus.main_ok, bus.sub_ok}), 32'b11);
    check("t3_data", 32'({bus.main_data, bus.sub_data}), 32'h0604);

    // Abandon: sub drops cs during WAIT, the fill still lands
    bus.main_cs  = 1'b0;
    bus.sub_addr = 15'h0020;
    tick();
    wait_req("t4");
    check("t4_addr", 32'(bus.sdram_addr), 32'h020010);
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack  = 1'b0;
    bus.sub_cs     = 1'b0;
    bus.sdram_rdy  = 1'b1;
    bus.sdram_dout = 16'hA5C3;
    tick();
    bus.sdram_rdy = 1'b0;
    check("t4_no_ok", 32'(bus.sub_ok), 32'd0);
    tick();
    check("t4_idle", 32'(bus.sdram_req), 32'd0);
    bus.sub_cs = 1'b1;
    #1;
    check("t4_ok",   32'(bus.sub_ok),   32'd1);
    check("t4_data", 32'(bus.sub_data), 32'hC3);
    tick();
    check("t4_noreq", 32'(bus.sdram_req), 32'd0);

    // Async reset while waiting for data
    bus.main_addr = 18'h00300;
    bus.main_cs   = 1'b1;
    tick();
    wait_req("t5");
    check("t5_addr", 32'(bus.sdram_addr), 32'h000180);
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    check("t5_sub_ok", 32'(bus.sub_ok), 32'd1);
    #5;
    rst         = 1'b1;
    bus.main_cs = 1'b0;
    #1;
    check("t5_rst_ok",  32'({bus.main_ok, bus.sub_ok, bus.mcu_ok}), 32'd0);
    check("t5_rst_req", 32'(bus.sdram_req), 32'd0);
    bus.sub_cs = 1'b0;
    tick();
    rst            = 1'b0;
    bus.sdram_rdy  = 1'b1;
    bus.sdram_dout = 16'hDEAD;
    tick();
    bus.sdram_rdy = 1'b0;
    bus.main_addr = 18'h00000;
    bus.main_cs   = 1'b1;
    #1;
    check("t5_stray", 32'(bus.main_ok), 32'd0);
    tick();
    check("t5_restart", 32'({bus.sdram_req, bus.sdram_addr}), 32'h400000);

    // Coincident ack+rdy in REQ
    bus.sdram_ack  = 1'b1;
    bus.sdram_rdy  = 1'b1;
    bus.sdram_dout = 16'h7788;
    tick();
    bus.sdram_ack = 1'b0;
    bus.sdram_rdy = 1'b0;
    check("t6_ok",   32'(bus.main_ok),   32'd1);
    check("t6_data", 32'(bus.main_data), 32'h88);
    check("t6_drop", 32'(bus.sdram_req), 32'd0);
    bus.main_cs  = 1'b0;
    bus.sub_addr = 15'h0004;
    bus.sub_cs   = 1'b1;
    tick();
    check("t6_next", 32'({bus.sdram_req, bus.sdram_addr}), 32'h420002);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
